// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and constants for the hyperbus transaction scheduler
package hyperbus_pkg;

  localparam int unsigned AddrW     = 32;
  localparam int unsigned LenW      = 16;
  localparam int unsigned ChipAddrW = 23;
  localparam int unsigned NChips    = 2;
  localparam int unsigned ChipIdxW  = (NChips > 1) ? $clog2(NChips) : 1;
  localparam int unsigned WordBytes = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // In flight, addr is the next segment's byte address and len the words still to issue.
  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
    logic             write;
  } req_t;

  typedef struct packed {
    logic [ChipAddrW-1:0] addr;
    logic [LenW-1:0]      len;
    logic                 write;
    logic [NChips-1:0]    cs;
    logic                 last;
  } seg_t;

endpackage

// File: rtl/hyperbus_seg_calc.sv
// rtl/hyperbus_seg_calc.sv - next-segment length, chip-boundary truncation and chip select decode
module hyperbus_seg_calc
  import hyperbus_pkg::*;
(
  input  logic [AddrW-1:0] addr_i,
  input  logic [LenW-1:0]  rem_i,
  input  logic [LenW-1:0]  max_words_i,
  input  logic             write_i,
  output seg_t             seg_o,
  output logic             err_o
);

  localparam int unsigned CmpW = ((ChipAddrW > LenW) ? ChipAddrW : LenW) + 1;
  localparam logic [ChipAddrW:0] ChipBytes = {1'b1, {ChipAddrW{1'b0}}};

  logic [ChipIdxW-1:0]  idx;
  logic [ChipAddrW-1:0] chip_addr;
  logic [ChipAddrW:0]   bytes_left;
  logic [CmpW-1:0]      bnd_words;
  logic [CmpW-1:0]      seg_w;

  assign idx       = addr_i[ChipAddrW +: ChipIdxW];
  assign chip_addr = addr_i[ChipAddrW-1:0];

  // Segment = min(remaining, max words if nonzero, words left before the chip end).
  always_comb begin
    err_o      = (32'(idx) >= NChips) || (addr_i[AddrW-1:ChipAddrW+ChipIdxW] != '0);
    bytes_left = ChipBytes - {1'b0, chip_addr};
    bnd_words  = CmpW'(bytes_left / (ChipAddrW+1)'(WordBytes));
    seg_w      = CmpW'(rem_i);
    if ((max_words_i != '0) && (CmpW'(max_words_i) < seg_w)) seg_w = CmpW'(max_words_i);
    if (bnd_words < seg_w) seg_w = bnd_words;
    seg_o.addr  = chip_addr;
    seg_o.len   = seg_w[LenW-1:0];
    seg_o.write = write_i;
    seg_o.cs    = err_o ? '0 : (NChips'(1) << idx);
    seg_o.last  = (seg_w == CmpW'(rem_i));
  end

endmodule

// File: rtl/hyperbus_txn_sched.sv
// rtl/hyperbus_txn_sched.sv - round-robin burst scheduler for the hyperbus PHY; HYPERBUS_SCHED_PERF_EN adds perf counters
module hyperbus_txn_sched
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips      = NChips,
  parameter int unsigned AddrWidth     = AddrW,
  parameter int unsigned ChipAddrWidth = ChipAddrW,
  parameter int unsigned LenWidth      = LenW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
`ifdef HYPERBUS_SCHED_PERF_EN
  input  logic                     perf_clr_i,
  output logic [31:0]              perf_seg_cnt_o,
  output logic [31:0]              perf_split_cnt_o,
`endif
  input  logic [LenWidth-1:0]      cfg_max_words_i,
  input  logic                     rd_valid_i,
  output logic                     rd_ready_o,
  input  logic [AddrWidth-1:0]     rd_addr_i,
  input  logic [LenWidth-1:0]      rd_len_i,
  output logic                     rd_done_o,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [AddrWidth-1:0]     wr_addr_i,
  input  logic [LenWidth-1:0]      wr_len_i,
  output logic                     wr_done_o,
  output logic                     err_o,
  output logic                     phy_valid_o,
  input  logic                     phy_ready_i,
  output logic [ChipAddrWidth-1:0] phy_addr_o,
  output logic [LenWidth-1:0]      phy_len_o,
  output logic                     phy_write_o,
  output logic [NumChips-1:0]      phy_cs_o,
  output logic                     phy_last_o,
  input  logic                     phy_done_i,
  output logic                     busy_o
);

  state_e state_q;
  req_t   cur_q;
  seg_t   seg_q;
  logic   phy_valid_q, rd_done_q, wr_done_q, err_q;
  logic   ptr_wr_q;

  logic   grant_rd, grant_wr, load, finish;
  req_t   calc_req;
  seg_t   calc_seg;
  logic   calc_err;

  // Arbitration and segment-load conditions; ready never looks at PHY handshakes.
  always_comb begin
    grant_rd = (state_q == IDLE) && rd_valid_i && (!wr_valid_i || !ptr_wr_q);
    grant_wr = (state_q == IDLE) && wr_valid_i && (!rd_valid_i || ptr_wr_q);
    load     = ((state_q == IDLE) && (grant_rd || grant_wr)) ||
               ((state_q == WAIT) && phy_done_i && (cur_q.len != '0));
    finish   = (state_q == WAIT) && phy_done_i && (cur_q.len == '0);
  end

  // Calculator sees the incoming request while idle and the in-flight remainder otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      calc_req.addr  = grant_wr ? wr_addr_i : rd_addr_i;
      calc_req.len   = grant_wr ? wr_len_i : rd_len_i;
      calc_req.write = grant_wr;
    end else begin
      calc_req = cur_q;
    end
  end

  hyperbus_seg_calc u_seg_calc (
    .addr_i      (calc_req.addr),
    .rem_i       (calc_req.len),
    .max_words_i (cfg_max_words_i),
    .write_i     (calc_req.write),
    .seg_o       (calc_seg),
    .err_o       (calc_err)
  );

  // Main sequencer: grant, issue one segment, wait for PHY completion, respond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      seg_q       <= '0;
      phy_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
      ptr_wr_q    <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      if (state_q == IDLE && load) cur_q <= calc_req;
      if (load) begin
        if (calc_err) begin
          state_q   <= RESP;
          err_q     <= 1'b1;
          rd_done_q <= !calc_req.write;
          wr_done_q <= calc_req.write;
        end else begin
          state_q     <= ISSUE;
          phy_valid_q <= 1'b1;
          seg_q       <= calc_seg;
        end
      end
      if (finish) begin
        state_q   <= RESP;
        rd_done_q <= !cur_q.write;
        wr_done_q <= cur_q.write;
      end
      case (state_q)
        ISSUE: if (phy_ready_i) begin
          cur_q.addr  <= cur_q.addr + AddrW'(seg_q.len) * AddrW'(WordBytes);
          cur_q.len   <= cur_q.len - seg_q.len;
          phy_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        RESP: begin
          ptr_wr_q <= !cur_q.write;
          state_q  <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rd_ready_o  = grant_rd;
  assign wr_ready_o  = grant_wr;
  assign rd_done_o   = rd_done_q;
  assign wr_done_o   = wr_done_q;
  assign err_o       = err_q;
  assign phy_valid_o = phy_valid_q;
  assign phy_addr_o  = seg_q.addr;
  assign phy_len_o   = seg_q.len;
  assign phy_write_o = seg_q.write;
  assign phy_cs_o    = seg_q.cs;
  assign phy_last_o  = seg_q.last;
  assign busy_o      = (state_q != IDLE);

`ifdef HYPERBUS_SCHED_PERF_EN
  logic [31:0] seg_cnt_q, seg_cnt_d, split_cnt_q, split_cnt_d;

  // Saturating event counters; clear beats a same-cycle increment.
  always_comb begin
    seg_cnt_d   = seg_cnt_q;
    split_cnt_d = split_cnt_q;
    if (perf_clr_i) begin
      seg_cnt_d   = '0;
      split_cnt_d = '0;
    end else begin
      if (phy_valid_q && phy_ready_i && (seg_cnt_q != '1)) seg_cnt_d = seg_cnt_q + 32'd1;
      if ((state_q == IDLE) && load && !calc_err && !calc_seg.last && (split_cnt_q != '1))
        split_cnt_d = split_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_cnt_q   <= '0;
      split_cnt_q <= '0;
    end else begin
      seg_cnt_q   <= seg_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign perf_seg_cnt_o   = seg_cnt_q;
  assign perf_split_cnt_o = split_cnt_q;
`endif

endmodule

// File: tb/tb_hyperbus_txn_sched.sv
// tb/tb_hyperbus_txn_sched.sv - self-checking bench for hyperbus_txn_sched
module tb_hyperbus_txn_sched;

  logic        clk, rst_n;
  logic [15:0] cfg_max;
  logic        rd_valid, rd_ready, rd_done;
  logic [31:0] rd_addr;
  logic [15:0] rd_len;
  logic        wr_valid, wr_ready, wr_done;
  logic [31:0] wr_addr;
  logic [15:0] wr_len;
  logic        err;
  logic        phy_valid, phy_ready, phy_write, phy_last, phy_done, busy;
  logic [22:0] phy_addr;
  logic [15:0] phy_len;
  logic [1:0]  phy_cs;
`ifdef HYPERBUS_SCHED_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_seg, perf_split;
`endif

  int checks;
  int failures;

  hyperbus_txn_sched dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
`ifdef HYPERBUS_SCHED_PERF_EN
    .perf_clr_i      (perf_clr),
    .perf_seg_cnt_o  (perf_seg),
    .perf_split_cnt_o(perf_split),
`endif
    .cfg_max_words_i (cfg_max),
    .rd_valid_i      (rd_valid),
    .rd_ready_o      (rd_ready),
    .rd_addr_i       (rd_addr),
    .rd_len_i        (rd_len),
    .rd_done_o       (rd_done),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .wr_addr_i       (wr_addr),
    .wr_len_i        (wr_len),
    .wr_done_o       (wr_done),
    .err_o           (err),
    .phy_valid_o     (phy_valid),
    .phy_ready_i     (phy_ready),
    .phy_addr_o      (phy_addr),
    .phy_len_o       (phy_len),
    .phy_write_o     (phy_write),
    .phy_cs_o        (phy_cs),
    .phy_last_o      (phy_last),
    .phy_done_i      (phy_done),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and services it; expected segments come from plain address arithmetic.
  task automatic run_req(input bit wr, input logic [31:0] addr, input int unsigned len,
                         input int unsigned cfg, input bit vary_cfg,
                         output int nseg, output bit got_err);
    longint unsigned a, chip, loc;
    int unsigned rem, seg, room;
    bit fin;
    a = 64'(addr); rem = len; nseg = 0; got_err = 0; fin = 0;
    cfg_max = cfg[15:0];
    if (wr) begin wr_valid = 1; wr_addr = addr; wr_len = len[15:0]; end
    else    begin rd_valid = 1; rd_addr = addr; rd_len = len[15:0]; end
    #1;
    chk("grant_ready", wr ? wr_ready : rd_ready, 1);
    chk("grant_other", wr ? rd_ready : wr_ready, 0);
    @(negedge clk);
    rd_valid = 0; wr_valid = 0;
    while (!fin) begin
      chip = a >> 23;
      loc  = a & 64'h7F_FFFF;
      if (rem == 0 || chip >= 2) begin
        got_err = (rem != 0);
        chk("done_rd", rd_done, !wr);
        chk("done_wr", wr_done, wr);
        chk("done_err", err, got_err);
        chk("done_no_phy", phy_valid, 0);
        fin = 1;
      end else begin
        room = int'((64'h80_0000 - loc) / 2);
        seg = rem;
        if (cfg_max != 0 && cfg_max < seg) seg = cfg_max;
        if (room < seg) seg = room;
        nseg++;
        chk("seg_valid", phy_valid, 1);
        chk("seg_addr", phy_addr, loc);
        chk("seg_len", phy_len, seg);
        chk("seg_write", phy_write, wr);
        chk("seg_cs", phy_cs, 64'd1 << chip);
        chk("seg_last", phy_last, seg == rem);
        chk("seg_busy", busy, 1);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("stall_valid", phy_valid, 1);
          chk("stall_len", phy_len, seg);
          chk("stall_addr", phy_addr, loc);
        end
        phy_ready = 1;
        @(negedge clk);
        phy_ready = 0;
        chk("hs_drop_valid", phy_valid, 0);
        rem -= seg;
        a += 64'(2 * seg);
        if (vary_cfg) cfg_max = 16'($urandom_range(0, 10));
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("early_done", rd_done | wr_done, 0);
        end
        phy_done = 1;
        @(negedge clk);
        phy_done = 0;
      end
    end
    @(negedge clk);
    chk("done_clear", {rd_done, wr_done, err}, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int nseg;
    bit gerr;
    logic [31:0] addr;
    bit exp_rd;
    checks = 0; failures = 0;
    rst_n = 0; cfg_max = 0;
    rd_valid = 0; rd_addr = 0; rd_len = 0;
    wr_valid = 0; wr_addr = 0; wr_len = 0;
    phy_ready = 0; phy_done = 0;
`ifdef HYPERBUS_SCHED_PERF_EN
    perf_clr = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_phy_valid", phy_valid, 0);
    chk("rst_done", {rd_done, wr_done, err}, 0);
    chk("rst_cs", phy_cs, 0);
    chk("rst_ready", {rd_ready, wr_ready}, 0);
    rst_n = 1;
    @(negedge clk);

    // Both sides requesting: grants alternate R,W,R,W starting with read.
    rd_addr = 32'h200; rd_len = 2; wr_addr = 32'h400; wr_len = 3; cfg_max = 0;
    rd_valid = 1; wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp_rd = (i % 2 == 0);
      #1;
      chk("rr_rd_ready", rd_ready, exp_rd);
      chk("rr_wr_ready", wr_ready, !exp_rd);
      @(negedge clk);
      if (exp_rd) rd_valid = 0; else wr_valid = 0;
      chk("rr_phy_valid", phy_valid, 1);
      chk("rr_phy_write", phy_write, !exp_rd);
      chk("rr_phy_len", phy_len, exp_rd ? 2 : 3);
      phy_ready = 1;
      @(negedge clk);
      phy_ready = 0; phy_done = 1;
      @(negedge clk);
      phy_done = 0;
      chk("rr_rd_done", rd_done, exp_rd);
      chk("rr_wr_done", wr_done, !exp_rd);
      @(negedge clk);
      if (exp_rd) rd_valid = 1; else wr_valid = 1;
    end
    rd_valid = 0; wr_valid = 0;
    @(negedge clk);

    // Directed scenarios.
    run_req(0, 32'h100, 8, 0, 0, nseg, gerr);
    chk("s1_nseg", nseg, 1);
    run_req(1, 32'h0, 20, 8, 0, nseg, gerr);
    chk("s2_nseg", nseg, 3);
    run_req(0, 32'h7F_FFF8, 8, 0, 0, nseg, gerr);
    chk("s4_nseg", nseg, 2);
    run_req(1, 32'h0100_0000, 4, 0, 0, nseg, gerr);
    chk("s5_nseg", nseg, 0);
    chk("s5_err", gerr, 1);
    run_req(0, 32'h00FF_FFFC, 6, 0, 0, nseg, gerr);
    chk("xchip_err", gerr, 1);

    // Randomized requests, including boundary crossings and bad chips.
    for (int i = 0; i < 25; i++) begin
      addr = $urandom & 32'h7F_FFFE;
      case ($urandom_range(0, 5))
        0, 1, 2: addr = addr | ($urandom_range(0, 1) << 23);
        3:       addr = ($urandom_range(0, 1) << 23) | (32'h80_0000 - 2 * $urandom_range(1, 24));
        4:       addr = addr | 32'h0100_0000;
        default: addr = addr | 32'h4000_0000;
      endcase
      run_req(1'($urandom_range(0, 1)), addr, $urandom_range(1, 40), $urandom_range(0, 12),
              1'($urandom_range(0, 1)), nseg, gerr);
    end

    // Reset in the middle of a request: no done, everything back to idle.
    rd_valid = 1; rd_addr = 32'h100; rd_len = 4; cfg_max = 0;
    @(negedge clk);
    rd_valid = 0;
    chk("mid_valid", phy_valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", phy_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cs", phy_cs, 0);
    @(negedge clk);
    rst_n = 1; phy_done = 1;
    @(negedge clk);
    phy_done = 0;
    chk("stray_done", {rd_done, wr_done, err}, 0);
    chk("stray_busy", busy, 0);
    rd_valid = 1; wr_valid = 1;
    #1;
    chk("rst_ptr_read", {rd_ready, wr_ready}, 2'b10);
    rd_valid = 0; wr_valid = 0;
    @(negedge clk);

`ifdef HYPERBUS_SCHED_PERF_EN
    chk("perf_rst_seg", perf_seg, 0);
    run_req(1, 32'h0, 20, 8, 0, nseg, gerr);
    chk("perf_seg", perf_seg, 3);
    chk("perf_split", perf_split, 1);
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    chk("perf_clr_seg", perf_seg, 0);
    chk("perf_clr_split", perf_split, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
